vit_acs_scheduler: RTL and testbench

//  Sequences the time-multiplexed BMC/ACS array of the K=7, rate-1/2 Viterbi decoder.

---
 rtl/vit_pkg.sv | 20 ++
 rtl/vit_tb_req_ctrl.sv | 29 ++
 rtl/vit_acs_scheduler.sv | 120 ++++++++++++
 tb/tb_vit_acs_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// vit_pkg: shared Viterbi decoder dimensions, survivor address width helper and scheduler state encoding
package vit_pkg;
    localparam int N_STATES    = 64;
    localparam int N_BFLY_PAR  = 8;
    localparam int G           = N_STATES / 2 / N_BFLY_PAR;
    localparam int PM_W        = 8;
    localparam int TB_LEN      = 32;
    localparam int NORM_THRESH = 128;
    localparam int GRP_W       = $clog2(G);
    localparam int SYM_W       = $clog2(2 * TB_LEN);
    localparam int WIN_W       = $clog2(TB_LEN);

    function automatic int sp_addr_w(input int tb_len, input int grps);
        return $clog2(2 * tb_len * grps);
    endfunction

    localparam int SP_AW = sp_addr_w(TB_LEN, G);

    typedef enum logic [1:0] {IDLE, RUN, TB_WAIT, FLUSH} state_t;
endpackage

// File: rtl/vit_tb_req_ctrl.sv
// vit_tb_req_ctrl: holds one traceback request stable until the traceback unit acknowledges it
module vit_tb_req_ctrl
    import vit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SYM_W-1:0] load_start,
    input  logic             load_last,
    input  logic             ack,
    output logic             req,
    output logic [SYM_W-1:0] start,
    output logic             last
);
    // a load is only presented while no request is pending; ack without a request is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= 1'b0;
            start <= '0;
            last  <= 1'b0;
        end else if (load) begin
            req   <= 1'b1;
            start <= load_start;
            last  <= load_last;
        end else if (ack && req) begin
            req   <= 1'b0;
        end
    end
endmodule

// File: rtl/vit_acs_scheduler.sv
// vit_acs_scheduler: symbol intake, ACS group sequencing, PM bank ping-pong, normalization and traceback hand-off
module vit_acs_scheduler
    import vit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_pair,
    input  logic             flush,
    output logic [1:0]       bmc_pair,
    output logic             acs_en,
    output logic [GRP_W-1:0] grp_idx,
    output logic             pm_bank_sel,
    output logic             pm_init,
    input  logic [PM_W-1:0]  grp_min,
    output logic [PM_W-1:0]  norm_sub,
    output logic             sp_wr_en,
    output logic [SP_AW-1:0] sp_wr_addr,
    output logic             tb_req,
    output logic [SYM_W-1:0] tb_start,
    output logic             tb_last,
    input  logic             tb_ack
);
    state_t           state, state_nxt;
    logic [SYM_W-1:0] sym_cnt;
    logic [PM_W-1:0]  min_acc, min_new;
    logic             fl_sent, fl_empty, fl_done;
    logic             last_grp, sym_end, boundary, stall, accept;
    logic             tb_load, tb_load_last;
    logic [SYM_W-1:0] tb_load_start;

    assign last_grp = grp_idx == GRP_W'(G - 1);
    assign sym_end  = state == RUN && last_grp;
    assign boundary = sym_cnt[WIN_W-1:0] == '1;
    assign stall    = boundary && tb_req;
    assign accept   = sym_valid && sym_ready;
    assign min_new  = grp_min < min_acc ? grp_min : min_acc;
    assign fl_empty = sym_cnt[WIN_W-1:0] == '0;
    assign fl_done  = state == FLUSH && (fl_sent ? tb_ack && tb_req : !tb_req && fl_empty);

    // window requests: on a boundary, deferred after an overrun stall, or the final partial window on flush
    assign tb_load       = (sym_end && boundary && !tb_req)
                         || (!tb_req && (state == TB_WAIT || (state == FLUSH && !fl_sent && !fl_empty)));
    assign tb_load_start = state == RUN ? sym_cnt : sym_cnt - 1'b1;
    assign tb_load_last  = state == FLUSH;

    assign sp_wr_en   = acs_en;
    assign sp_wr_addr = {sym_cnt, grp_idx};

    vit_tb_req_ctrl u_tb_req (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tb_load),
        .load_start (tb_load_start),
        .load_last  (tb_load_last),
        .ack        (tb_ack),
        .req        (tb_req),
        .start      (tb_start),
        .last       (tb_last)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: a new symbol wins over flush; an overrun at a window boundary parks in TB_WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : flush ? FLUSH : IDLE;
            RUN:     state_nxt = !last_grp || accept ? RUN : stall ? TB_WAIT : IDLE;
            TB_WAIT: state_nxt = tb_req ? TB_WAIT : IDLE;
            FLUSH:   state_nxt = fl_done ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ACS runs only in RUN; the next pair is taken on the last group unless stalled
    always_comb begin
        acs_en    = state == RUN;
        sym_ready = state == IDLE || (sym_end && !stall);
    end

    // pair capture, group/symbol counters, bank ping-pong, running minimum and normalization
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmc_pair    <= '0;
            grp_idx     <= '0;
            sym_cnt     <= '0;
            pm_bank_sel <= 1'b0;
            pm_init     <= 1'b1;
            norm_sub    <= '0;
            min_acc     <= '1;
            fl_sent     <= 1'b0;
        end else begin
            if (accept) bmc_pair <= sym_pair;
            if (acs_en) begin
                grp_idx <= last_grp ? '0 : grp_idx + 1'b1;
                min_acc <= last_grp ? '1 : min_new;
            end
            if (sym_end) begin
                pm_bank_sel <= ~pm_bank_sel;
                pm_init     <= 1'b0;
                norm_sub    <= min_new >= PM_W'(NORM_THRESH) ? PM_W'(NORM_THRESH) : '0;
                sym_cnt     <= sym_cnt + 1'b1;
            end
            if (tb_load && state == FLUSH) fl_sent <= 1'b1;
            if (fl_done) begin
                fl_sent     <= 1'b0;
                sym_cnt     <= '0;
                pm_bank_sel <= 1'b0;
                pm_init     <= 1'b1;
                norm_sub    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vit_acs_scheduler.sv
// tb_vit_acs_scheduler: symbol-level reference model plus directed and table-driven checks of the ACS scheduler
module tb_vit_acs_scheduler;
    logic       clk = 0, rst_n = 0, sym_valid = 0, flush = 0, tb_ack = 0;
    logic [1:0] sym_pair = '0;
    logic [7:0] grp_min = '1;
    logic       sym_ready, acs_en, pm_bank_sel, pm_init, sp_wr_en, tb_req, tb_last;
    logic [1:0] bmc_pair, grp_idx;
    logic [7:0] norm_sub, sp_wr_addr;
    logic [5:0] tb_start;

    vit_acs_scheduler dut (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_pair(sym_pair),
        .flush(flush), .bmc_pair(bmc_pair), .acs_en(acs_en), .grp_idx(grp_idx), .pm_bank_sel(pm_bank_sel),
        .pm_init(pm_init), .grp_min(grp_min), .norm_sub(norm_sub), .sp_wr_en(sp_wr_en), .sp_wr_addr(sp_wr_addr),
        .tb_req(tb_req), .tb_start(tb_start), .tb_last(tb_last), .tb_ack(tb_ack)
    );

    always #5 clk = ~clk;

    int errs = 0, chks = 0, cyc = 0;
    // symbol-level model: queue of accepted pairs, symbols done in frame, expected window requests
    logic [1:0] pq[$];
    int         rq[$];
    logic [1:0] cur_pair;
    int         sym_no, grp_no, mn, exp_norm, acc_n = 0;
    logic       prev_req, prev_ack;
    int         prev_start, req_age, ack_dly, ack_max = 1;
    bit         ack_en = 1;
    int         a0, c0, n, r;

    typedef struct { logic [31:0] mins; int norm; } nrow_t;
    nrow_t nt[7];

    task automatic chk(input string nm, input int act, input int exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete(); rq.delete();
        sym_no = 0; grp_no = 0; mn = 255; exp_norm = 0;
        prev_req = 0; prev_ack = 0; prev_start = 0; req_age = 0; ack_dly = 1; tb_ack = 0;
    endtask

    // one clock: drive the ack responder, check this cycle against the model, advance to next negedge
    task automatic tick();
        tb_ack = ack_en && tb_req && req_age >= ack_dly;
        if (acs_en) begin
            if (grp_no == 0) begin
                chk("acs_has_pair", int'(pq.size() > 0), 1);
                cur_pair = pq.size() > 0 ? pq.pop_front() : 2'b00;
            end
            chk("grp_idx", int'(grp_idx), grp_no);
            chk("bmc_pair", int'(bmc_pair), int'(cur_pair));
            chk("sp_wr_en", int'(sp_wr_en), 1);
            chk("sp_wr_addr", int'(sp_wr_addr), (sym_no % 64) * 4 + grp_no);
            chk("norm_sub", int'(norm_sub), exp_norm);
            chk("pm_bank_sel", int'(pm_bank_sel), sym_no % 2);
            chk("pm_init", int'(pm_init), int'(sym_no == 0));
            if (int'(grp_min) < mn) mn = int'(grp_min);
            grp_no++;
            if (grp_no == 4) begin
                grp_no = 0; exp_norm = mn >= 128 ? 128 : 0; mn = 255; sym_no++;
                if (sym_no % 32 == 0) rq.push_back((sym_no + 63) % 64);
            end
        end else begin
            chk("acs_gap", grp_no, 0);
            chk("sp_wr_en_idle", int'(sp_wr_en), 0);
        end
        if (sym_valid && sym_ready) begin pq.push_back(sym_pair); acc_n++; end
        if (tb_req) begin
            if (!prev_req || prev_ack) begin
                if (tb_last) begin
                    chk("flush_start", int'(tb_start), (sym_no + 63) % 64);
                    chk("flush_partial", int'(sym_no % 32 != 0), 1);
                end else begin
                    chk("req_expected", int'(rq.size() > 0), 1);
                    if (rq.size() > 0) chk("tb_start", int'(tb_start), rq.pop_front());
                end
            end else chk("tb_start_stable", int'(tb_start), prev_start);
            if (tb_ack) begin req_age = 0; ack_dly = $urandom_range(1, ack_max); end
            else req_age++;
        end
        prev_req = tb_req; prev_ack = tb_ack; prev_start = int'(tb_start);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; sym_valid = 0; flush = 0; ack_max = 1; ack_en = 1;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic send_sym(input logic [1:0] p, input logic [31:0] m);
        int k = 0;
        sym_valid = 1; sym_pair = p;
        while (!sym_ready && k < 1000) begin tick(); k++; end
        chk("accept_timeout", int'(k < 1000), 1);
        tick();
        sym_valid = 0;
        for (int g = 0; g < 4; g++) begin grp_min = m[8*g +: 8]; tick(); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nt[0] = '{32'h81C8828C, 128};
        nt[1] = '{32'hC8C8C87F, 0};
        nt[2] = '{32'h80808080, 128};
        nt[3] = '{32'hFFFFFFFF, 128};
        nt[4] = '{32'h7FC8C8C8, 0};
        nt[5] = '{32'hFEFF8081, 128};
        nt[6] = '{32'hFFFFFF00, 0};

        do_reset();
        chk("rst_sym_ready", int'(sym_ready), 1);
        chk("rst_pm_init", int'(pm_init), 1);
        chk("rst_acs_en", int'(acs_en), 0);
        chk("rst_tb_req", int'(tb_req), 0);
        chk("rst_tb_start", int'(tb_start), 0);
        chk("rst_tb_last", int'(tb_last), 0);
        chk("rst_norm_sub", int'(norm_sub), 0);
        chk("rst_bmc_pair", int'(bmc_pair), 0);
        chk("rst_bank", int'(pm_bank_sel), 0);
        chk("rst_addr", int'(sp_wr_addr), 0);

        // single pair 2'b10
        sym_valid = 1; sym_pair = 2'b10; tick(); sym_valid = 0;
        for (int g = 0; g < 4; g++) begin
            chk("t1_acs_en", int'(acs_en), 1);
            chk("t1_grp", int'(grp_idx), g);
            chk("t1_pm_init", int'(pm_init), 1);
            chk("t1_bank", int'(pm_bank_sel), 0);
            chk("t1_pair", int'(bmc_pair), 2);
            tick();
        end
        chk("t1_acs_off", int'(acs_en), 0);
        chk("t1_pm_init_after", int'(pm_init), 0);
        chk("t1_bank_after", int'(pm_bank_sel), 1);

        // normalization table
        for (int i = 0; i < 7; i++) begin
            send_sym(2'($urandom), nt[i].mins);
            chk("t4_norm_sub", int'(norm_sub), nt[i].norm);
        end

        // back-to-back symbols with prompt acks
        do_reset();
        sym_valid = 1; a0 = acc_n; c0 = cyc; n = 0;
        while (acc_n - a0 < 65 && n < 2000) begin sym_pair = 2'($urandom); grp_min = 8'($urandom); tick(); n++; end
        chk("t2_cycles", cyc - c0, 257);
        sym_valid = 0;
        repeat (4) tick();
        chk("t2_addr_wrapped", int'(sp_wr_addr), 4);
        chk("t2_req_drained", rq.size(), 0);

        // withheld ack forces the overrun stall
        do_reset();
        ack_en = 0; sym_valid = 1; a0 = acc_n; n = 0;
        while (acc_n - a0 < 64 && n < 2000) begin sym_pair = 2'($urandom); grp_min = 8'($urandom); tick(); n++; end
        chk("t3_accepts", acc_n - a0, 64);
        repeat (3) tick();
        chk("t3_grp_last", int'(grp_idx), 3);
        chk("t3_ready_blocked", int'(sym_ready), 0);
        chk("t3_req_held", int'(tb_req), 1);
        chk("t3_start_held", int'(tb_start), 31);
        tick();
        chk("t3_wait_acs", int'(acs_en), 0);
        chk("t3_wait_ready", int'(sym_ready), 0);
        a0 = acc_n;
        repeat (6) tick();
        chk("t3_no_accept", acc_n - a0, 0);
        ack_en = 1; n = 0;
        while (tb_req && n < 20) begin tick(); n++; end
        n = 0;
        while (!tb_req && n < 20) begin tick(); n++; end
        chk("t3_second_req", int'(tb_req), 1);
        chk("t3_second_start", int'(tb_start), 63);
        n = 0;
        while (acc_n == a0 && n < 20) begin tick(); n++; end
        chk("t3_resumed", int'(acc_n > a0), 1);
        sym_valid = 0;
        repeat (6) tick();

        // flush after 40 symbols
        do_reset();
        for (int i = 0; i < 40; i++) send_sym(2'($urandom), i == 39 ? 32'hC8C8C8C8 : $urandom);
        chk("t5_norm_before", int'(norm_sub), 128);
        flush = 1; tick(); flush = 0;
        n = 0;
        while (!tb_req && n < 50) begin tick(); n++; end
        chk("t5_req", int'(tb_req), 1);
        chk("t5_start", int'(tb_start), 39);
        chk("t5_last", int'(tb_last), 1);
        n = 0;
        while (tb_req && n < 50) begin tick(); n++; end
        chk("t5_req_done", int'(tb_req), 0);
        chk("t5_addr", int'(sp_wr_addr), 0);
        chk("t5_pm_init", int'(pm_init), 1);
        chk("t5_bank", int'(pm_bank_sel), 0);
        chk("t5_norm", int'(norm_sub), 0);
        chk("t5_ready", int'(sym_ready), 1);
        model_reset();

        // flush after exactly one full window: no extra request
        for (int i = 0; i < 32; i++) send_sym(2'($urandom), $urandom);
        repeat (3) tick();
        chk("t5b_req_acked", int'(tb_req), 0);
        chk("t5b_addr_before", int'(sp_wr_addr), 128);
        flush = 1; tick(); flush = 0;
        r = 0;
        repeat (8) begin r += int'(tb_req); tick(); end
        chk("t5b_no_req", r, 0);
        chk("t5b_addr", int'(sp_wr_addr), 0);
        chk("t5b_pm_init", int'(pm_init), 1);
        model_reset();

        // asynchronous reset mid-symbol with a pending request and active normalization
        do_reset();
        ack_en = 0;
        for (int i = 0; i < 32; i++) send_sym(2'($urandom), 32'hC8C8C8C8);
        chk("t6_req_pending", int'(tb_req), 1);
        chk("t6_norm_before", int'(norm_sub), 128);
        sym_valid = 1; sym_pair = 2'b01; tick(); sym_valid = 0;
        tick(); tick();
        chk("t6_grp2", int'(grp_idx), 2);
        #2 rst_n = 0;
        #1;
        chk("t6_acs_async", int'(acs_en), 0);
        chk("t6_req_async", int'(tb_req), 0);
        chk("t6_norm_async", int'(norm_sub), 0);
        chk("t6_pm_init_async", int'(pm_init), 1);
        @(negedge clk);
        rst_n = 1; ack_en = 1;
        model_reset();
        @(negedge clk);
        chk("t6_ready_after", int'(sym_ready), 1);
        chk("t6_addr_after", int'(sp_wr_addr), 0);
        send_sym(2'b11, 32'h90909090);

        // randomized traffic with random ack latency
        do_reset();
        ack_max = 150;
        repeat (1500) begin
            sym_valid = $urandom_range(0, 3) != 0;
            sym_pair  = 2'($urandom);
            grp_min   = 8'($urandom_range(100, 255));
            tick();
        end
        sym_valid = 0;
        repeat (400) tick();
        chk("rand_pairs_consumed", pq.size(), 0);
        chk("rand_reqs_issued", rq.size(), 0);
        chk("rand_grp_aligned", grp_no, 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
